// File: rtl/dcc_layer_scheduler.sv
// Time-multiplexed signed 8x8 MAC across NUM_LAYERS dilated causal conv layers (dilation 2^l).
// Optional residual path per layer: define WAVENET_RESIDUAL_EN.
module dcc_layer_scheduler #(
    parameter int NUM_LAYERS  = 4,
    parameter int KERNEL_SIZE = 3,
    parameter int ACC_W       = 20
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [7:0]                                  in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [7:0]                                  out_data,
    input  logic                                        coef_we,
    input  logic [$clog2(NUM_LAYERS*KERNEL_SIZE)-1:0]   coef_addr,
    input  logic [7:0]                                  coef_data,
    output logic                                        busy
);

    localparam int NC   = NUM_LAYERS * KERNEL_SIZE;
    localparam int CW   = $clog2(NC);
    localparam int SPAN = (2 ** (NUM_LAYERS - 1)) * (KERNEL_SIZE - 1) + 1;
    localparam int HW   = $clog2(SPAN);
    localparam int HD   = 2 ** HW;
    localparam int LW   = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam int KW   = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(128);

    typedef enum logic [2:0] {IDLE, LOAD, MAC, SAT, OUT} state_t;

    state_t                   state_r;
    logic [LW-1:0]            l_r;
    logic [KW-1:0]            k_r;
    logic [HW-1:0]            ptr_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic [7:0]               x_r;
    logic [7:0]               hist_r [NUM_LAYERS][HD];
    logic [7:0]               coef_r [NC];
    logic [7:0]               out_data_r;
    logic                     out_valid_r;
    logic                     in_ready_r;
    logic                     busy_r;

    logic [HW-1:0]            tap_idx_s;
    logic [CW-1:0]            coef_idx_s;
    logic signed [7:0]        tap_smp_s;
    logic signed [7:0]        tap_coef_s;
    logic signed [15:0]       prod_s;
    logic signed [ACC_W-1:0]  sat_in_s;
    logic [7:0]               y_s;

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] v);
        logic [7:0] r;
        if (v >= SAT_HI) begin
            r = 8'h7f;
        end else if (v <= SAT_LO) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    // Tap addressing, product and saturation for the current layer/tap
    always_comb begin
        tap_idx_s  = ptr_r - (HW'(k_r) << l_r);
        coef_idx_s = CW'(l_r) * CW'(KERNEL_SIZE) + CW'(k_r);
        tap_smp_s  = hist_r[l_r][tap_idx_s];
        tap_coef_s = coef_r[coef_idx_s];
        prod_s     = tap_smp_s * tap_coef_s;
`ifdef WAVENET_RESIDUAL_EN
        sat_in_s   = acc_r + {{(ACC_W-8){x_r[7]}}, x_r};
`else
        sat_in_s   = acc_r;
`endif
        y_s        = sat8(sat_in_s);
    end

    // Sequencing FSM, history, coefficient file and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            l_r         <= LW'(0);
            k_r         <= KW'(0);
            ptr_r       <= HW'(0);
            acc_r       <= ACC_W'(0);
            x_r         <= 8'h00;
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            for (int l = 0; l < NUM_LAYERS; l++) begin
                for (int i = 0; i < HD; i++) begin
                    hist_r[l][i] <= 8'h00;
                end
            end
            for (int i = 0; i < NC; i++) begin
                coef_r[i] <= 8'((i % KERNEL_SIZE) + 1);
            end
        end else begin
            case (state_r)
                IDLE: begin
                    // a write in the accept cycle lands before the sample is used
                    if (coef_we && ({1'b0, coef_addr} < (CW+1)'(NC))) begin
                        coef_r[coef_addr] <= coef_data;
                    end
                    if (in_valid && in_ready_r) begin
                        x_r        <= in_data;
                        l_r        <= LW'(0);
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= LOAD;
                    end
                end
                LOAD: begin
                    hist_r[l_r][ptr_r] <= x_r;
                    acc_r              <= ACC_W'(0);
                    k_r                <= KW'(0);
                    state_r            <= MAC;
                end
                MAC: begin
                    acc_r <= acc_r + {{(ACC_W-16){prod_s[15]}}, prod_s};
                    if (k_r == KW'(KERNEL_SIZE - 1)) begin
                        state_r <= SAT;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                SAT: begin
                    if (l_r == LW'(NUM_LAYERS - 1)) begin
                        out_data_r  <= y_s;
                        out_valid_r <= 1'b1;
                        state_r     <= OUT;
                    end else begin
                        x_r     <= y_s;
                        l_r     <= l_r + LW'(1);
                        state_r <= LOAD;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        ptr_r       <= ptr_r + HW'(1);
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

endmodule
